// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB writeback stage and the load extender.
package mem_wb_stage_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extend.sv
// Big-endian byte/halfword extraction with sign/zero extension and misalignment detect.
module load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] load_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] ext_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = load_data[31:24];
            2'd1:    byte_sel = load_data[23:16];
            2'd2:    byte_sel = load_data[15:8];
            default: byte_sel = load_data[7:0];
        endcase
        half_sel = offset[1] ? load_data[15:0] : load_data[31:16];
    end

    // Unknown encodings behave as LW.
    always_comb begin
        ext_data   = load_data;
        misaligned = (offset != 2'd0);
        case (load_type)
            LT_LH: begin
                ext_data   = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LT_LHU: begin
                ext_data   = {16'h0000, half_sel};
                misaligned = offset[0];
            end
            LT_LB: begin
                ext_data   = {{24{byte_sel[7]}}, byte_sel};
                misaligned = 1'b0;
            end
            LT_LBU: begin
                ext_data   = {24'h000000, byte_sel};
                misaligned = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback select for the 5-stage MIPS pipeline.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic                  mem_to_reg,
    input  logic                  mem_link,
    input  logic [2:0]            mem_load_type,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_load_data,
    input  logic [DATA_W-1:0]     mem_pc_plus4,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic                  wb_reg_write,
    output logic                  wb_misaligned,
    output logic [31:0]           wb_retire_count
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  to_reg_q;
    logic                  link_q;
    logic [2:0]            load_type_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     load_data_q;
    logic [DATA_W-1:0]     pc_plus4_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [31:0]           retire_count_q;

    logic [DATA_W-1:0]     ext_data;
    logic                  load_misaligned;

    // Flush loads zeros rather than leaving the payload fields stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            to_reg_q     <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= 3'b000;
            alu_result_q <= '0;
            load_data_q  <= '0;
            pc_plus4_q   <= '0;
            write_reg_q  <= '0;
        end else if (!stall) begin
            valid_q      <= mem_valid;
            reg_write_q  <= mem_reg_write;
            to_reg_q     <= mem_to_reg;
            link_q       <= mem_link;
            load_type_q  <= mem_load_type;
            alu_result_q <= mem_alu_result;
            load_data_q  <= mem_load_data;
            pc_plus4_q   <= mem_pc_plus4;
            write_reg_q  <= mem_write_reg;
        end
    end

    // The WB instruction leaves on any unstalled edge, even one that flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retire_count_q <= '0;
        else if (valid_q && !stall)
            retire_count_q <= retire_count_q + 32'd1;
    end

    load_extend u_load_extend (
        .load_data  (load_data_q),
        .offset     (alu_result_q[1:0]),
        .load_type  (load_type_q),
        .ext_data   (ext_data),
        .misaligned (load_misaligned)
    );

    always_comb begin
        if (link_q)
            wb_write_data = pc_plus4_q + DATA_W'(4);
        else if (to_reg_q)
            wb_write_data = ext_data;
        else
            wb_write_data = alu_result_q;
    end

    assign wb_misaligned   = valid_q & to_reg_q & load_misaligned;
    assign wb_write_reg    = write_reg_q;
    assign wb_reg_write    = valid_q & reg_write_q & (write_reg_q != REG_ADDR_W'(REG_ZERO))
                             & ~wb_misaligned;
    assign wb_retire_count = retire_count_q;

endmodule
